seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider_pkg.sv | 21 ++
 rtl/seq_restoring_divider_if.sv | 29 ++
 rtl/seq_restoring_divider_div_step.sv | 28 ++
 rtl/seq_restoring_divider.sv | 133 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Default widths follow the companion 4-bit adder-with-memory datapath:
// a 5-bit sum feeds the dividend, and a 4-bit operand feeds the divisor.
package divider_pkg;

    localparam int DEF_DIVIDEND_W = 5;
    localparam int DEF_DIVISOR_W  = 4;

    // One quotient bit is produced per step, so the step count equals the dividend width.
    localparam int STEP_COUNT = DEF_DIVIDEND_W;

    // Quotient reported for a zero divisor.
    localparam logic [DEF_DIVIDEND_W-1:0] QUOT_SAT = 5'h1F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/result bundle for the sequential restoring divider.
// The master drives the operands and start; the slave (the divider) returns status and results.
interface seq_restoring_divider_if
    import divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
);

    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits. Purely combinational so it
// can be replicated if the divider is ever unrolled or pipelined.
module div_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W:0]   i_pr,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W:0]   o_nextPr,
    output logic                 o_qBit
);

    logic [DIVISOR_W+1:0] w_trial;
    logic [DIVISOR_W+1:0] w_divisorExt;
    logic [DIVISOR_W:0]   w_diff;

    assign w_trial      = {i_pr, i_bit};
    assign w_divisorExt = {2'b00, i_divisor};

    // Incoming partial remainder is always below the divisor, so any difference
    // that is kept fits back into the partial-remainder width.
    assign w_diff = w_trial[DIVISOR_W:0] - {1'b0, i_divisor};

    assign o_qBit   = (w_trial >= w_divisorExt);
    assign o_nextPr = o_qBit ? w_diff : w_trial[DIVISOR_W:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// A zero divisor finishes after a single RUN cycle with a saturated quotient.
// Optional build macro DIVIDER_EARLY_EXIT_EN: a dividend smaller than a non-zero
// divisor also finishes after a single RUN cycle (quotient 0, remainder = dividend).
module seq_restoring_divider
    import divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input logic                    clk,
    input logic                    rst,
    seq_restoring_divider_if.slave bus
);

    localparam int STEPS = (DIVIDEND_W == DEF_DIVIDEND_W) ? STEP_COUNT : DIVIDEND_W;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [DIVIDEND_W-1:0] SAT_Q =
        (DIVIDEND_W == DEF_DIVIDEND_W) ? DIVIDEND_W'(QUOT_SAT) : {DIVIDEND_W{1'b1}};

    state_t                r_state;
    state_t                w_nextState;
    logic [DIVIDEND_W-1:0] r_shift;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVISOR_W:0]    r_pr;
    logic [CNT_W-1:0]      r_count;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_dbz;

    logic                  w_divZero;
    logic                  w_lastStep;
    logic                  w_shortcut;
    logic                  w_qBit;
    logic [DIVISOR_W:0]    w_nextPr;
    logic [DIVIDEND_W-1:0] w_nextShift;

    // r_shift holds the dividend bits still to be consumed at the top and
    // collects quotient bits at the bottom, so after the last step it is the quotient.
    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .i_pr      (r_pr),
        .i_bit     (r_shift[DIVIDEND_W-1]),
        .i_divisor (r_divisor),
        .o_nextPr  (w_nextPr),
        .o_qBit    (w_qBit)
    );

    assign w_nextShift = {r_shift[DIVIDEND_W-2:0], w_qBit};
    assign w_divZero   = (r_divisor == '0);
    assign w_lastStep  = (r_count == CNT_W'(1));

    // Shortcut cases are decided in the first RUN cycle, while r_shift still
    // holds the untouched dividend; this keeps done one cycle after capture.
`ifdef DIVIDER_EARLY_EXIT_EN
    logic [DIVIDEND_W-1:0] w_divisorExt;
    assign w_divisorExt = {{(DIVIDEND_W-DIVISOR_W){1'b0}}, r_divisor};
    assign w_shortcut   = (r_count == CNT_W'(STEPS)) && (w_divZero || (r_shift < w_divisorExt));
`else
    assign w_shortcut   = (r_count == CNT_W'(STEPS)) && w_divZero;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: accept a request in IDLE, finish on shortcut or last step, pulse DONE once.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_nextState = RUN;
            RUN:     if (w_shortcut || w_lastStep) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: capture operands, step the division, and update results only on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_divisor   <= '0;
            r_pr        <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_shift   <= bus.dividend;
                        r_divisor <= bus.divisor;
                        r_pr      <= '0;
                        r_count   <= CNT_W'(STEPS);
                    end
                end
                RUN: begin
                    if (w_shortcut) begin
                        r_quotient  <= w_divZero ? SAT_Q : '0;
                        r_remainder <= r_shift[DIVISOR_W-1:0];
                        r_dbz       <= w_divZero;
                        r_count     <= '0;
                    end else begin
                        r_pr    <= w_nextPr;
                        r_shift <= w_nextShift;
                        r_count <= r_count - CNT_W'(1);
                        if (w_lastStep) begin
                            r_quotient  <= w_nextShift;
                            r_remainder <= w_nextPr[DIVISOR_W-1:0];
                            r_dbz       <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = (r_state == DONE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard testbench for seq_restoring_divider.
// Stimulus pushes the reference result and its expected done edge; an
// independent monitor checks busy/done every cycle, pops on done, and checks
// that results hold between operations.
module tb_seq_restoring_divider;
    import divider_pkg::*;

    typedef struct {
        logic [4:0] q;
        logic [3:0] r;
        logic       dbz;
        int         doneEdge;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    seq_restoring_divider_if bus ();

    seq_restoring_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   edgeCount    = 0;
    int   assertCount  = 0;
    int   failCount    = 0;
    int   activeE0     = -10;
    int   activeEd     = -10;
    int   nextFreeEdge = 0;
    logic [4:0] heldQ   = '0;
    logic [3:0] heldR   = '0;
    logic       heldDbz = 1'b0;
    bit         monitorEn = 1'b0;
    exp_t sb[$];

    // Count rising edges so expectations can be phrased in edge numbers.
    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edgeCount);
        end
    endtask

    // Issue one request on the first edge the reference model says is free; push the expected outcome.
    task automatic applyStimulus(input logic [4:0] dvd, input logic [3:0] dvs);
        exp_t e;
        int   lat;
        int   guard;
        int   a;
        int   b;
        guard = 0;
        @(posedge clk); #2;
        while ((edgeCount + 1 < nextFreeEdge) && (guard < 200)) begin
            @(posedge clk); #2;
            guard++;
        end
        a = int'(dvd);
        b = int'(dvs);
        if (b == 0) begin
            e.q   = 5'h1F;
            e.r   = dvd[3:0];
            e.dbz = 1'b1;
            lat   = 1;
        end else begin
            e.q   = 5'(a / b);
            e.r   = 4'(a % b);
            e.dbz = 1'b0;
            lat   = 5;
`ifdef DIVIDER_EARLY_EXIT_EN
            if (a < b) lat = 1;
`endif
        end
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        activeE0     = edgeCount + 1;
        activeEd     = activeE0 + lat;
        nextFreeEdge = activeEd + 2;
        e.doneEdge   = activeEd;
        sb.push_back(e);
        @(posedge clk); #2;
        bus.start    = 1'b0;
        bus.dividend = 5'($urandom_range(31));
        bus.divisor  = 4'($urandom_range(15));
    endtask

    // Monitor: status every cycle, results on done, held results otherwise.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (monitorEn) begin
            checkOutput("busy", 32'(bus.busy), 32'((edgeCount >= activeE0) && (edgeCount <= activeEd)));
            checkOutput("done", 32'(bus.done), 32'(edgeCount == activeEd));
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("done with empty scoreboard", 32'(bus.done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("done edge", 32'(edgeCount), 32'(e.doneEdge));
                    checkOutput("quotient", 32'(bus.quotient), 32'(e.q));
                    checkOutput("remainder", 32'(bus.remainder), 32'(e.r));
                    checkOutput("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
                    heldQ   = e.q;
                    heldR   = e.r;
                    heldDbz = e.dbz;
                end
            end else begin
                checkOutput("held quotient", 32'(bus.quotient), 32'(heldQ));
                checkOutput("held remainder", 32'(bus.remainder), 32'(heldR));
                checkOutput("held div_by_zero", 32'(bus.div_by_zero), 32'(heldDbz));
                if ((sb.size() > 0) && (edgeCount > sb[0].doneEdge)) begin
                    checkOutput("done timeout", 32'(bus.done), 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Main sequence: directed cases, an ignored request, a reset abort, then random operations.
    initial begin
        int guard;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        monitorEn    = 1'b1;
        #2;
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset quotient", 32'(bus.quotient), 32'd0);
        checkOutput("reset remainder", 32'(bus.remainder), 32'd0);
        checkOutput("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        applyStimulus(5'd30, 4'd4);
        applyStimulus(5'd31, 4'd1);
        applyStimulus(5'd31, 4'd15);
        applyStimulus(5'd9,  4'd0);
        applyStimulus(5'd10, 4'd5);
        applyStimulus(5'd3,  4'd7);

        applyStimulus(5'd20, 4'd3);
        @(posedge clk); #2;
        bus.start    = 1'b1;
        bus.dividend = 5'd6;
        bus.divisor  = 4'd2;
        @(posedge clk); #2;
        bus.start    = 1'b0;

        applyStimulus(5'd25, 4'd4);
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort done", 32'(bus.done), 32'd0);
        checkOutput("abort quotient", 32'(bus.quotient), 32'd0);
        checkOutput("abort remainder", 32'(bus.remainder), 32'd0);
        checkOutput("abort div_by_zero", 32'(bus.div_by_zero), 32'd0);
        sb.delete();
        heldQ        = '0;
        heldR        = '0;
        heldDbz      = 1'b0;
        activeE0     = -10;
        activeEd     = -10;
        nextFreeEdge = 0;
        @(posedge clk); #2;
        rst = 1'b0;
        applyStimulus(5'd25, 4'd4);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(5'($urandom_range(31)), 4'($urandom_range(15)));
            if ($urandom_range(1) == 1) repeat ($urandom_range(3)) @(posedge clk);
        end

        guard = 0;
        while ((sb.size() > 0) && (guard < 50)) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
